lshift_rot_seq: RTL and testbench

Sequential 32-bit left shifter/rotator. It complements the datapath's right-shift barrel stages and completes the shift unit of the 32-bit processor. An operand, a 5-bit amount and a shift/rotate select are captured on a start handshake. The unit applies one binary-weighted left stage (1, 2, 4, 8, 16) per clock and presents the result with a one-cycle done pulse. Fixed latency keeps control-unit stall logic trivial.

---
 rtl/lshift_rot_seq.sv | 120 ++++++++++++
 tb/tb_lshift_rot_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lshift_rot_seq.sv
// lshift_rot_seq: sequential 32-bit left shifter / rotator.
// Captures an operand, a 5-bit amount and a shift/rotate select on start,
// then applies one binary-weighted left stage (1, 2, 4, 8, 16) per clock.
// The result appears on y together with a one-cycle done pulse, at a fixed
// latency of 6 cycles from the accepting edge.
module lshift_rot_seq #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift_rot,
    input  logic [STAGES-1:0] r,
    input  logic [WIDTH-1:0]  x,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  y
);

    localparam int STG_W = $clog2(STAGES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  stage_out;
    logic [WIDTH-1:0]  acc_step;
    logic [STAGES-1:0] amt_q;
    logic              mode_q;
    logic [STG_W-1:0]  stg;

    logic              accept;
    logic              last_stage;

    // A new request is taken only when the unit is not mid-operation.
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_stage = (stg == STG_W'(STAGES - 1));

    // State register; rst is synchronous and overrides any start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last_stage) state_next = DONE;
            DONE: state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded directly from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:  busy = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // One left stage of weight 2^stg: zero fill for shift, wrap for rotate.
    always_comb begin
        stage_out = acc;
        for (int s = 0; s < STAGES; s++) begin
            if (stg == STG_W'(s)) begin
                if (mode_q) begin
                    stage_out = (acc << (1 << s)) | (acc >> (WIDTH - (1 << s)));
                end else begin
                    stage_out = acc << (1 << s);
                end
            end
        end
        acc_step = amt_q[stg] ? stage_out : acc;
    end

    // Datapath: operand capture, per-stage update and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            amt_q  <= '0;
            mode_q <= 1'b0;
            stg    <= '0;
            y      <= '0;
        end else if (accept) begin
            acc    <= x;
            amt_q  <= r;
            mode_q <= shift_rot;
            stg    <= '0;
        end else if (state == RUN) begin
            acc <= acc_step;
            if (last_stage) begin
                stg <= '0;
                y   <= acc_step;
            end else begin
                stg <= stg + STG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lshift_rot_seq.sv
// tb_lshift_rot_seq: directed and randomized checks of lshift_rot_seq
// against a bit-by-bit arithmetic reference of left shift / rotate.
module tb_lshift_rot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        shift_rot;
    logic [4:0]  r;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int tests = 0;
    int fails = 0;

    lshift_rot_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_rot (shift_rot),
        .r         (r),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .y         (y)
    );

    always #5 clk = ~clk;

    // Reference: move the value left one position at a time; in rotate
    // mode the bit leaving position 31 re-enters at position 0.
    function automatic logic [31:0] ref_model(logic [31:0] v, int amt, bit rot);
        longint unsigned a = 64'(v);
        longint unsigned m = 64'h1_0000_0000;
        logic [63:0] tmp;
        for (int i = 0; i < amt; i++) begin
            a = a * 2;
            if (a >= m) a = rot ? (a - m + 1) : (a - m);
        end
        tmp = 64'(a);
        return tmp[31:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after capture, and check
    // busy length, done position (6th cycle after the start edge) and y.
    task automatic run_op(string tag, logic [31:0] xv, logic [4:0] rv, logic mode);
        logic [31:0] exp;
        int busy_cnt;
        int done_k;
        exp      = ref_model(xv, int'(rv), mode);
        busy_cnt = 0;
        done_k   = -1;
        @(negedge clk);
        start = 1'b1; x = xv; r = rv; shift_rot = mode;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; x = $urandom; r = 5'($urandom); shift_rot = 1'($urandom);
            end
            if (busy) busy_cnt++;
            if (done && done_k < 0) done_k = k;
            if (k == 5) check({tag, " y"}, y, exp);
        end
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd5);
        check({tag, " done_cycle"}, 32'(done_k), 32'd5);
    endtask

    initial begin
        logic [31:0] x1, x2, exp1, exp2;
        logic [4:0]  r1, r2;
        logic        m1, m2;
        int          done_early;
        int          stray_done;
        int          y_drift;

        rst = 1'b1; start = 1'b0; shift_rot = 1'b0; r = '0; x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset y", y, 32'h0);
        rst = 1'b0;

        // Directed cases.
        run_op("shift 1<<31", 32'h0000_0001, 5'd31, 1'b0);
        run_op("shift 80000001 r1", 32'h8000_0001, 5'd1, 1'b0);
        run_op("rot 80000001 r1", 32'h8000_0001, 5'd1, 1'b1);
        run_op("rot 12345678 r16", 32'h1234_5678, 5'd16, 1'b1);
        run_op("rot F000000F r4", 32'hF000_000F, 5'd4, 1'b1);
        run_op("shift r0", 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op("rot r0", 32'hDEAD_BEEF, 5'd0, 1'b1);
        run_op("rot ones r13", 32'hFFFF_FFFF, 5'd13, 1'b1);
        run_op("shift ones r31", 32'hFFFF_FFFF, 5'd31, 1'b0);
        @(negedge clk);
        check("idle after done", 32'(done), 32'd0);

        // Start held high through RUN with changing operands; second op
        // accepted in the DONE cycle.
        x1 = $urandom; r1 = 5'($urandom_range(1, 31)); m1 = 1'b1;
        exp1 = ref_model(x1, int'(r1), m1);
        x2 = '0; r2 = '0; m2 = 1'b0;
        done_early = 0; stray_done = 0; y_drift = 0;
        start = 1'b1; x = x1; r = r1; shift_rot = m1;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 5 && done) done_early++;
            if (k == 5) begin
                check("b2b first done", 32'(done), 32'd1);
                check("b2b first y", y, exp1);
            end
            if (k > 5 && k < 11) begin
                if (done) stray_done++;
                if (y !== exp1) y_drift++;
            end
            if (k == 11) begin
                check("b2b second done", 32'(done), 32'd1);
                check("b2b second y", y, exp2);
            end
            if (k <= 5) begin
                start = 1'b1; x = $urandom; r = 5'($urandom); shift_rot = 1'($urandom);
                if (k == 5) begin
                    x2 = x; r2 = r; m2 = shift_rot;
                    exp2 = ref_model(x2, int'(r2), m2);
                end
            end else begin
                start = 1'b0;
            end
        end
        check("b2b no early done", 32'(done_early), 32'd0);
        check("b2b no stray done", 32'(stray_done), 32'd0);
        check("b2b y held", 32'(y_drift), 32'd0);

        // Reset asserted during the third RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; x = 32'h0F0F_0F0F; r = 5'd7; shift_rot = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort y", y, 32'h0);
        stray_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        check("abort no done", 32'(stray_done), 32'd0);
        run_op("after abort", 32'hA5A5_0001, 5'd9, 1'b1);

        // rst and start together: start must not be captured.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; x = 32'h1; r = 5'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst beats start", 32'(busy), 32'd0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), $urandom, 5'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
